// File: rtl/scope_capture_pkg.sv
// Shared types and constants for the scope capture block: FSM states,
// default record geometry, trigger-direction encoding and the crossing test.
package scope_capture_pkg;

  localparam int SAMPLE_W       = 8;
  localparam int DEF_DEPTH_BITS = 9;
  localparam int DEF_PRE_TRIG   = 128;

  localparam logic TRIG_RISING  = 1'b1;
  localparam logic TRIG_FALLING = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRETRIG   = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POSTTRIG  = 3'd3,
    ST_READOUT   = 3'd4
  } state_t;

  // True when the step prev -> cur crosses lvl in the armed direction.
  function automatic logic trig_cross(
    input logic                rising,
    input logic [SAMPLE_W-1:0] prev,
    input logic [SAMPLE_W-1:0] cur,
    input logic [SAMPLE_W-1:0] lvl
  );
    if (rising == TRIG_RISING)
      return (prev < lvl) && (cur >= lvl);
    return (prev > lvl) && (cur <= lvl);
  endfunction

endpackage

// File: rtl/scope_capture_if.sv
// Readout stream from the capture buffer to the host-link bridge.
interface scope_capture_if;
  import scope_capture_pkg::*;

  logic [SAMPLE_W-1:0] oRd_Data;
  logic                oRd_Valid;
  logic                iRd_Ready;

  modport master (output oRd_Data, output oRd_Valid, input iRd_Ready);
  modport slave  (input oRd_Data, input oRd_Valid, output iRd_Ready);
endinterface

// File: rtl/scope_capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port,
// no reset on storage so it maps onto block RAM.
module scope_capture_ram
  import scope_capture_pkg::*;
#(
  parameter int pDepthBits = DEF_DEPTH_BITS
) (
  input  logic                  iClk,
  input  logic                  iWe,
  input  logic [pDepthBits-1:0] iWAddr,
  input  logic [SAMPLE_W-1:0]   iWData,
  input  logic                  iRe,
  input  logic [pDepthBits-1:0] iRAddr,
  output logic [SAMPLE_W-1:0]   oRData
);

  logic [SAMPLE_W-1:0] r_mem [0:(1<<pDepthBits)-1];

  always_ff @(posedge iClk) begin
    if (iWe)
      r_mem[iWAddr] <= iWData;
    if (iRe)
      oRData <= r_mem[iRAddr];
  end

endmodule

// File: rtl/scope_capture.sv
// Ring-buffer capture of an ADC sample stream around a level or forced
// trigger, then oldest-first readout of the frozen record over valid/ready.
module scope_capture
  import scope_capture_pkg::*;
#(
  parameter int pDepthBits = DEF_DEPTH_BITS,
  parameter int pPreTrig   = DEF_PRE_TRIG
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic [SAMPLE_W-1:0] iADC_Data,
  input  logic                iData_Valid,
  input  logic                iArm,
  input  logic [SAMPLE_W-1:0] iTrigLevel,
  input  logic                iTrigRising,
  input  logic                iForceTrig,
  scope_capture_if.master     rd,
  output logic                oBusy,
  output logic                oTriggered,
  output logic                oDone
);

  localparam int D  = 1 << pDepthBits;
  localparam int CW = pDepthBits + 1;
  localparam logic [CW-1:0]         PRE_CNT  = CW'(pPreTrig);
  localparam logic [CW-1:0]         POST_CNT = CW'(D - pPreTrig);
  localparam logic [CW-1:0]         REC_CNT  = CW'(D);
  localparam logic [pDepthBits-1:0] PRE_OFF  = pDepthBits'(pPreTrig);

  state_t                r_state, w_state_nxt;
  logic [pDepthBits-1:0] r_wptr, r_rptr;
  logic [CW-1:0]         r_cnt, w_cnt_inc;
  logic [SAMPLE_W-1:0]   r_prev, r_level, r_data_p1, w_ram_q;
  logic                  r_rising, r_force, r_trig, r_done;
  logic                  r_vld_p0, r_vld_p1;
  logic                  w_wr, w_hit, w_issue, w_accept, w_last;

  assign w_wr      = iData_Valid && ((r_state == ST_PRETRIG) ||
                     (r_state == ST_WAIT_TRIG) || (r_state == ST_POSTTRIG));
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_hit     = (r_state == ST_WAIT_TRIG) && iData_Valid &&
                     (r_force || iForceTrig || trig_cross(r_rising, r_prev, iADC_Data, r_level));
  assign w_accept  = r_vld_p1 && rd.iRd_Ready;
  assign w_last    = w_accept && (w_cnt_inc == REC_CNT);
  // First read fires on READOUT entry; each later one is chained to an accept.
  assign w_issue   = (r_state == ST_READOUT) && !r_vld_p0 &&
                     ((!r_vld_p1 && (r_cnt == '0)) || (w_accept && !w_last));

  always_ff @(posedge iClk) begin
    if (iRst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (iArm) w_state_nxt = ST_PRETRIG;
      ST_PRETRIG:   if (w_wr && (w_cnt_inc == PRE_CNT)) w_state_nxt = ST_WAIT_TRIG;
      ST_WAIT_TRIG: if (w_hit) w_state_nxt = (POST_CNT == CW'(1)) ? ST_READOUT : ST_POSTTRIG;
      ST_POSTTRIG:  if (w_wr && (w_cnt_inc == POST_CNT)) w_state_nxt = ST_READOUT;
      ST_READOUT:   if (w_last) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_force   <= 1'b0;
      r_trig    <= 1'b0;
      r_done    <= 1'b0;
      r_vld_p0  <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
    end else begin
      r_done <= w_last;
      if (w_wr)
        r_wptr <= r_wptr + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (iArm) begin
            r_cnt   <= '0;
            r_force <= 1'b0;
          end
        end
        ST_PRETRIG, ST_POSTTRIG: begin
          if (w_wr)
            r_cnt <= (w_state_nxt != r_state) ? '0 : w_cnt_inc;
        end
        ST_WAIT_TRIG: begin
          if (iForceTrig)
            r_force <= 1'b1;
          if (w_hit) begin
            r_rptr  <= r_wptr - PRE_OFF;
            r_trig  <= 1'b1;
            r_force <= 1'b0;
            r_cnt   <= (POST_CNT == CW'(1)) ? '0 : CW'(1);
          end
        end
        ST_READOUT: begin
          if (w_issue)
            r_rptr <= r_rptr + 1'b1;
          if (w_accept)
            r_cnt <= w_last ? '0 : w_cnt_inc;
          if (w_last)
            r_trig <= 1'b0;
        end
        default: ;
      endcase
      // p0: read issued to RAM -> p1: sample registered and held for the host
      r_vld_p0 <= w_issue;
      if (r_vld_p0) begin
        r_vld_p1  <= 1'b1;
        r_data_p1 <= w_ram_q;
      end else if (w_accept) begin
        r_vld_p1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if ((r_state == ST_IDLE) && iArm) begin
      r_level  <= iTrigLevel;
      r_rising <= iTrigRising;
    end
    if (w_wr)
      r_prev <= iADC_Data;
  end

  scope_capture_ram #(.pDepthBits(pDepthBits)) u_ram (
    .iClk   (iClk),
    .iWe    (w_wr),
    .iWAddr (r_wptr),
    .iWData (iADC_Data),
    .iRe    (w_issue),
    .iRAddr (r_rptr),
    .oRData (w_ram_q)
  );

  assign rd.oRd_Data  = r_data_p1;
  assign rd.oRd_Valid = r_vld_p1;
  assign oBusy        = (r_state != ST_IDLE);
  assign oTriggered   = r_trig;
  assign oDone        = r_done;

endmodule

// File: tb/tb_scope_capture.sv
// Scoreboard bench for scope_capture: a sample-list trigger model pushes the
// expected record; an independent monitor pops it on every readout handshake.
module tb_scope_capture;

  localparam int DB = 4;
  localparam int D  = 1 << DB;
  localparam int P  = 4;

  logic       iClk = 1'b0;
  logic       iRst, iData_Valid, iArm, iTrigRising, iForceTrig;
  logic [7:0] iADC_Data, iTrigLevel;
  logic       oBusy, oTriggered, oDone;

  scope_capture_if bus();

  scope_capture #(.pDepthBits(DB), .pPreTrig(P)) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iADC_Data   (iADC_Data),
    .iData_Valid (iData_Valid),
    .iArm        (iArm),
    .iTrigLevel  (iTrigLevel),
    .iTrigRising (iTrigRising),
    .iForceTrig  (iForceTrig),
    .rd          (bus),
    .oBusy       (oBusy),
    .oTriggered  (oTriggered),
    .oDone       (oDone)
  );

  always #5 iClk = ~iClk;

  int         checks = 0;
  int         errors = 0;
  int         rd_count = 0;
  int         rdy_mode = 0;
  logic [7:0] s [0:79];
  logic [7:0] exp_q [$];

  task automatic check_eq(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Reference trigger rule over the list of captured samples.
  function automatic int find_trig(input logic [7:0] lvl, input bit rising,
                                   input int fi, input int n);
    for (int i = P; i < n; i++) begin
      if (fi >= P && i >= fi) return i;
      if (rising && s[i-1] < lvl && s[i] >= lvl) return i;
      if (!rising && s[i-1] > lvl && s[i] <= lvl) return i;
    end
    return -1;
  endfunction

  task automatic send(input int i, input bit frc);
    repeat (7) tick();
    iForceTrig = frc;
    tick();
    iForceTrig  = 1'b0;
    iData_Valid = 1'b1;
    iADC_Data   = s[i];
    tick();
    iData_Valid = 1'b0;
    iADC_Data   = 8'($urandom);
  endtask

  task automatic capture(input string nm, input logic [7:0] lvl, input bit rising,
                         input int fi, input int n, input int stop_after, input bit arm_in_ro);
    int t, last, cyc;
    t = find_trig(lvl, rising, fi, n);
    if (t < 0 || t + D - P - 1 >= n) begin
      checks++;
      errors++;
      $display("FAIL %s_model: no trigger inside stimulus, t=%0d", nm, t);
      return;
    end
    last = (stop_after < 0) ? t + D - P - 1 : t + stop_after;
    if (stop_after < 0)
      for (int k = t - P; k < t + D - P; k++) exp_q.push_back(s[k]);
    rd_count = 0;
    iTrigLevel  = lvl;
    iTrigRising = rising;
    iArm        = 1'b1;
    tick();
    iArm        = 1'b0;
    iTrigLevel  = ~lvl;
    iTrigRising = !rising;
    @(negedge iClk);
    check_eq({nm, "_busy_after_arm"}, oBusy, 1);
    for (int i = 0; i <= last; i++) begin
      send(i, (i == 1) || (i == fi && fi <= t));
      @(negedge iClk);
      check_eq({nm, "_triggered"}, oTriggered, (i >= t) ? 1 : 0);
      check_eq({nm, "_busy"}, oBusy, 1);
    end
    if (stop_after >= 0) return;
    if (arm_in_ro) begin
      cyc = 0;
      while (!bus.oRd_Valid && cyc < 20) begin
        @(negedge iClk);
        cyc++;
      end
      tick();
      iArm = 1'b1;
      tick();
      iArm = 1'b0;
    end
    cyc = 0;
    while (!oDone && cyc < 3000) begin
      @(negedge iClk);
      cyc++;
    end
    check_eq({nm, "_done_seen"}, oDone, 1);
    check_eq({nm, "_beats"}, rd_count, D);
    check_eq({nm, "_left_in_queue"}, exp_q.size(), 0);
    check_eq({nm, "_busy_at_done"}, oBusy, 0);
    check_eq({nm, "_valid_at_done"}, bus.oRd_Valid, 0);
    check_eq({nm, "_trig_at_done"}, oTriggered, 0);
    @(negedge iClk);
    check_eq({nm, "_done_pulse_width"}, oDone, 0);
    check_eq({nm, "_no_restart"}, oBusy, 0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string nm);
    check_eq({nm, "_busy"}, oBusy, 0);
    check_eq({nm, "_triggered"}, oTriggered, 0);
    check_eq({nm, "_done"}, oDone, 0);
    check_eq({nm, "_valid"}, bus.oRd_Valid, 0);
    check_eq({nm, "_data"}, bus.oRd_Data, 0);
  endtask

  // Monitor: compares every accepted beat and the hold-while-stalled rule.
  initial begin : monitor
    bit         stall;
    logic [7:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge iClk);
      if (iRst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check_eq("stall_valid_held", bus.oRd_Valid, 1);
          check_eq("stall_data_held", bus.oRd_Data, held);
        end
        if (bus.oRd_Valid && bus.iRd_Ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_extra_beat: got 0x%0h, required no beat", bus.oRd_Data);
          end else begin
            check_eq("rd_data", bus.oRd_Data, exp_q.pop_front());
          end
          rd_count++;
        end
        stall = bus.oRd_Valid && !bus.iRd_Ready;
        held  = bus.oRd_Data;
      end
    end
  end

  initial begin : ready_driver
    bit tog;
    int stall_n;
    tog = 1'b1;
    stall_n = 0;
    bus.iRd_Ready = 1'b0;
    forever begin
      @(posedge iClk);
      #1;
      if (rdy_mode == 0) begin
        bus.iRd_Ready = 1'b1;
      end else if (stall_n > 0) begin
        bus.iRd_Ready = 1'b0;
        stall_n--;
      end else begin
        bus.iRd_Ready = tog;
        tog = !tog;
        if ($urandom_range(0, 3) == 0) stall_n = $urandom_range(1, 5);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int t;
    iRst = 1'b1; iData_Valid = 1'b0; iArm = 1'b0; iForceTrig = 1'b0;
    iTrigRising = 1'b0; iADC_Data = '0; iTrigLevel = '0;
    repeat (3) tick();
    @(negedge iClk);
    check_all_zero("reset_state");
    tick();
    iRst = 1'b0;

    // Reset in the middle of POSTTRIG, then a clean capture
    for (int i = 0; i < 40; i++) s[i] = 8'(8'h70 + i);
    capture("rst_mid", 8'h80, 1'b1, -1, 40, 3, 1'b0);
    iRst = 1'b1;
    tick();
    tick();
    iRst = 1'b0;
    @(negedge iClk);
    check_all_zero("rst_mid_after");
    exp_q.delete();

    iRst = 1'b1; iArm = 1'b1;
    tick();
    iRst = 1'b0; iArm = 1'b0;
    @(negedge iClk);
    check_eq("arm_with_reset_busy", oBusy, 0);

    capture("rise_ramp", 8'h80, 1'b1, -1, 40, -1, 1'b0);

    s[0] = 8'h30; s[1] = 8'h31; s[2] = 8'h32; s[3] = 8'h33;
    for (int i = 4; i < 40; i++) s[i] = 8'(8'h50 - (i - 4));
    capture("fall_ramp", 8'h40, 1'b0, -1, 40, -1, 1'b0);

    s[0] = 8'h7E; s[1] = 8'h7F; s[2] = 8'h80; s[3] = 8'h81;
    for (int i = 4; i < 40; i++) s[i] = 8'(8'h88 + i);
    capture("force", 8'h80, 1'b1, P + 5, 40, -1, 1'b0);

    for (int i = 0; i < 40; i++) s[i] = 8'(8'h70 + i);
    rdy_mode = 1;
    capture("stall_ready", 8'h80, 1'b1, -1, 40, -1, 1'b0);

    for (int i = 0; i < 80; i++) s[i] = 8'($urandom_range(0, 8'h7F));
    s[P + 44] = 8'h90;
    capture("long_wait", 8'h80, 1'b1, -1, 80, -1, 1'b1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 40; i++) s[i] = 8'($urandom);
      t = P + $urandom_range(0, 15);
      capture($sformatf("random%0d", r), 8'($urandom), 1'($urandom), t, 40, -1, 1'b0);
    end
    rdy_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
